// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon-style sequence player.
//   state_e      : controller states
//   color_t      : 2-bit color code (0..3)
//   color_onehot : color code -> one-hot LED pattern
//   max3         : largest of three cycle counts, used to size the phase counter
package simon_pkg;

    localparam int unsigned LED_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        APPEND,
        PLAY_ON,
        PLAY_OFF,
        INPUT,
        PASS,
        WIN,
        FAIL
    } state_e;

    typedef logic [1:0] color_t;

    function automatic logic [LED_W-1:0] color_onehot(input color_t c);
        logic [LED_W-1:0] oh;
        oh    = '0;
        oh[c] = 1'b1;
        return oh;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/seq_player_phase_timer.sv
// phase_timer: one-shot down counter for playback and input phases.
//   clk, rst : clock, asynchronous active-high reset
//   start_i  : load load_i and begin counting (takes priority over a running count)
//   load_i   : phase length in cycles (>= 1)
//   done_o   : high on the last cycle of the phase (load_i cycles after start_i)
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] load_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // Counter holds (remaining cycles - 1); zero while active marks the final cycle.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            cnt_d    = load_i - CNT_W'(1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/seq_player.sv
// seq_player: grows a random color sequence, plays it back on the LEDs and
// checks the player's presses against it.
//   clk, rst    : clock, asynchronous active-high reset
//   random_seq  : color appended each round
//   start       : begin a new game (IDLE/WIN/FAIL only)
//   btn_valid   : player press strobe, btn_code = pressed color
//   led         : one-hot color display, 4'b1111 on win
//   level       : stored sequence length
//   await_input : waiting for player presses
//   round_pass  : one-cycle pulse after a fully correct round
//   game_over   : sticky loss indication
//   game_won    : sticky win indication
// Optional build macro SEQ_PLAYER_TIMEOUT_EN: fail the game when no press
// arrives within TIMEOUT_CYCLES while waiting for input.
module seq_player
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned ON_CYCLES      = 25000000,
    parameter int unsigned OFF_CYCLES     = 12500000,
    parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   random_seq,
    input  logic                         start,
    input  logic                         btn_valid,
    input  logic [1:0]                   btn_code,
    output logic [3:0]                   led,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         await_input,
    output logic                         round_pass,
    output logic                         game_over,
    output logic                         game_won
);

    localparam int unsigned LVL_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W   = $clog2(MAX_LEN);
    localparam int unsigned MAX_CYC = max3(ON_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    state_e           state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    color_t           echo_q, echo_d;
    logic             echo_vld_q, echo_vld_d;
    color_t           mem_q [MAX_LEN];
    logic             mem_we;
    logic             tmr_start;
    logic [CNT_W-1:0] tmr_load;
    logic             tmr_done;
    logic             more_c;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (tmr_start),
        .load_i  (tmr_load),
        .done_o  (tmr_done)
    );

    // Another element remains after the current index.
    assign more_c = (LVL_W'(idx_q) + LVL_W'(1)) < level_q;

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        idx_d      = idx_q;
        echo_d     = echo_q;
        echo_vld_d = 1'b0;
        mem_we     = 1'b0;
        tmr_start  = 1'b0;
        tmr_load   = CNT_W'(ON_CYCLES);
        case (state_q)
            IDLE, WIN, FAIL: begin
                if (start) begin
                    state_d = APPEND;
                    level_d = '0;
                    idx_d   = '0;
                end
            end
            APPEND: begin
                mem_we    = 1'b1;
                level_d   = level_q + LVL_W'(1);
                idx_d     = '0;
                state_d   = PLAY_ON;
                tmr_start = 1'b1;
            end
            PLAY_ON: begin
                if (tmr_done) begin
                    state_d   = PLAY_OFF;
                    tmr_start = 1'b1;
                    tmr_load  = CNT_W'(OFF_CYCLES);
                end
            end
            PLAY_OFF: begin
                if (tmr_done) begin
                    if (more_c) begin
                        idx_d     = idx_q + IDX_W'(1);
                        state_d   = PLAY_ON;
                        tmr_start = 1'b1;
                    end else begin
                        idx_d   = '0;
                        state_d = INPUT;
`ifdef SEQ_PLAYER_TIMEOUT_EN
                        tmr_start = 1'b1;
                        tmr_load  = CNT_W'(TIMEOUT_CYCLES);
`endif
                    end
                end
            end
            INPUT: begin
                if (btn_valid) begin
                    echo_d     = btn_code;
                    echo_vld_d = 1'b1;
                    if (btn_code != mem_q[idx_q]) begin
                        state_d = FAIL;
                    end else if (more_c) begin
                        idx_d = idx_q + IDX_W'(1);
`ifdef SEQ_PLAYER_TIMEOUT_EN
                        tmr_start = 1'b1;
                        tmr_load  = CNT_W'(TIMEOUT_CYCLES);
`endif
                    end else begin
                        idx_d   = '0;
                        state_d = PASS;
                    end
                end
`ifdef SEQ_PLAYER_TIMEOUT_EN
                else if (tmr_done) begin
                    state_d = FAIL;
                end
`endif
            end
            PASS: begin
                state_d = (level_q == LVL_W'(MAX_LEN)) ? WIN : APPEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            level_q    <= '0;
            idx_q      <= '0;
            echo_q     <= '0;
            echo_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            echo_q     <= echo_d;
            echo_vld_q <= echo_vld_d;
        end
    end

    // Sequence storage; only read at indices already written this game.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[level_q[IDX_W-1:0]] <= random_seq;
        end
    end

    // LED mux; the press echo shows the live press, then the stored one for one more cycle.
    always_comb begin
        led = '0;
        case (state_q)
            PLAY_ON: led = color_onehot(mem_q[idx_q]);
            WIN:     led = '1;
            INPUT, PASS: begin
                if (state_q == INPUT && btn_valid) begin
                    led = color_onehot(btn_code);
                end else if (echo_vld_q) begin
                    led = color_onehot(echo_q);
                end
            end
            default: led = '0;
        endcase
    end

    assign level       = level_q;
    assign await_input = (state_q == INPUT);
    assign round_pass  = (state_q == PASS);
    assign game_over   = (state_q == FAIL);
    assign game_won    = (state_q == WIN);

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: the driver pushes the expected output vector for each
// driven cycle; a negedge monitor pops and compares.
module tb_seq_player;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned ON_C    = 3;
    localparam int unsigned OFF_C   = 2;
    localparam int unsigned TO_C    = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] random_seq;
    logic       start;
    logic       btn_valid;
    logic [1:0] btn_code;
    logic [3:0] led;
    logic [2:0] level;
    logic       await_input;
    logic       round_pass;
    logic       game_over;
    logic       game_won;

    seq_player #(
        .MAX_LEN        (MAX_LEN),
        .ON_CYCLES      (ON_C),
        .OFF_CYCLES     (OFF_C),
        .TIMEOUT_CYCLES (TO_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .random_seq  (random_seq),
        .start       (start),
        .btn_valid   (btn_valid),
        .btn_code    (btn_code),
        .led         (led),
        .level       (level),
        .await_input (await_input),
        .round_pass  (round_pass),
        .game_over   (game_over),
        .game_won    (game_won)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] led;
        logic [2:0] level;
        logic       aw;
        logic       rp;
        logic       go;
        logic       gw;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] seq [4];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] oh(input logic [1:0] c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

    // Monitor: compare DUT outputs against the expectation stamped for this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s stale expectation cyc=%0d now=%0d", e.tag, e.cyc, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if ({led, level, await_input, round_pass, game_over, game_won} !==
                {e.led, e.level, e.aw, e.rp, e.go, e.gw}) begin
                errors++;
                $display("FAIL %s cyc=%0d got led=%b lvl=%0d aw/rp/go/gw=%b%b%b%b exp led=%b lvl=%0d aw/rp/go/gw=%b%b%b%b",
                         e.tag, cyc, led, level, await_input, round_pass, game_over, game_won,
                         e.led, e.level, e.aw, e.rp, e.go, e.gw);
            end
        end
    end

    // Push the expectation for the current cycle, then advance one clock; pulses self-clear.
    task automatic exp_cyc(input string tag, input logic [3:0] l, input logic [2:0] lv,
                           input logic aw, input logic rp, input logic go, input logic gw);
        exp_t e;
        e.cyc = cyc; e.tag = tag; e.led = l; e.level = lv;
        e.aw = aw; e.rp = rp; e.go = go; e.gw = gw;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start     = 1'b0;
        btn_valid = 1'b0;
    endtask

    // APPEND cycle plus full playback of round n; optional ignored start/press during playback.
    task automatic play_round(input int n, input logic [1:0] newc, input logic poke);
        random_seq = newc;
        seq[n-1]   = newc;
        exp_cyc("append", 4'b0000, 3'(n-1), 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < int'(ON_C); k++) begin
                if (poke && i == 0 && k == 0) begin
                    start     = 1'b1;
                    btn_valid = 1'b1;
                    btn_code  = ~seq[0];
                end
                exp_cyc("play_on", oh(seq[i]), 3'(n), 0, 0, 0, 0);
            end
            for (int k = 0; k < int'(OFF_C); k++)
                exp_cyc("play_off", 4'b0000, 3'(n), 0, 0, 0, 0);
        end
    endtask

    // kind 0: correct, more to come; 1: correct, last; 2: wrong.
    task automatic press(input logic [1:0] code, input int kind, input int n);
        btn_valid = 1'b1;
        btn_code  = code;
        exp_cyc("press", oh(code), 3'(n), 1, 0, 0, 0);
        case (kind)
            0:       exp_cyc("echo", oh(code), 3'(n), 1, 0, 0, 0);
            1:       exp_cyc("pass", oh(code), 3'(n), 0, 1, 0, 0);
            default: exp_cyc("fail", 4'b0000, 3'(n), 0, 0, 1, 0);
        endcase
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_code = 2'b00; random_seq = 2'b00;
        @(posedge clk); #1;
        exp_cyc("reset", 4'b0000, 3'd0, 0, 0, 0, 0);
        exp_cyc("reset", 4'b0000, 3'd0, 0, 0, 0, 0);
        rst = 1'b0;
        exp_cyc("idle", 4'b0000, 3'd0, 0, 0, 0, 0);

        // Game 1: sequence 2,1,3,0 played to a win.
        start = 1'b1;
        exp_cyc("idle_start", 4'b0000, 3'd0, 0, 0, 0, 0);
        play_round(1, 2'b10, 1'b0);
        exp_cyc("input_wait", 4'b0000, 3'd1, 1, 0, 0, 0);
        press(2'b10, 1, 1);
        play_round(2, 2'b01, 1'b0);
        press(2'b10, 0, 2); press(2'b01, 1, 2);
        play_round(3, 2'b11, 1'b0);
        press(2'b10, 0, 3); press(2'b01, 0, 3); press(2'b11, 1, 3);
        play_round(4, 2'b00, 1'b0);
        press(2'b10, 0, 4); press(2'b01, 0, 4); press(2'b11, 0, 4); press(2'b00, 1, 4);
        exp_cyc("win", 4'b1111, 3'd4, 0, 0, 0, 1);
        btn_valid = 1'b1; btn_code = 2'b00;
        exp_cyc("win_btn", 4'b1111, 3'd4, 0, 0, 0, 1);
        exp_cyc("win_hold", 4'b1111, 3'd4, 0, 0, 0, 1);
        start = 1'b1;
        exp_cyc("win_start", 4'b1111, 3'd4, 0, 0, 0, 1);

        // Game 2: sequence 1,3,0; wrong press on element 2 of round 3.
        play_round(1, 2'b01, 1'b0);
        press(2'b01, 1, 1);
        play_round(2, 2'b11, 1'b1);
        press(2'b01, 0, 2); press(2'b11, 1, 2);
        play_round(3, 2'b00, 1'b0);
        press(2'b01, 0, 3); press(2'b10, 2, 3);
        btn_valid = 1'b1; btn_code = 2'b11;
        exp_cyc("fail_btn", 4'b0000, 3'd3, 0, 0, 1, 0);
        exp_cyc("fail_hold", 4'b0000, 3'd3, 0, 0, 1, 0);

        // Game 3: reset during round-2 playback.
        start = 1'b1;
        exp_cyc("fail_start", 4'b0000, 3'd3, 0, 0, 1, 0);
        play_round(1, 2'b10, 1'b0);
        press(2'b10, 1, 1);
        random_seq = 2'b01;
        exp_cyc("append", 4'b0000, 3'd1, 0, 0, 0, 0);
        exp_cyc("play_on", oh(2'b10), 3'd2, 0, 0, 0, 0);
        rst = 1'b1;
        exp_cyc("async_rst", 4'b0000, 3'd0, 0, 0, 0, 0);
        exp_cyc("rst_hold", 4'b0000, 3'd0, 0, 0, 0, 0);
        rst = 1'b0;
        exp_cyc("idle_after_rst", 4'b0000, 3'd0, 0, 0, 0, 0);

        // Game 4: input timeout behaviour.
        start = 1'b1;
        exp_cyc("idle_start", 4'b0000, 3'd0, 0, 0, 0, 0);
        play_round(1, 2'b11, 1'b0);
`ifdef SEQ_PLAYER_TIMEOUT_EN
        for (int i = 0; i < int'(TO_C); i++)
            exp_cyc("timeout_wait", 4'b0000, 3'd1, 1, 0, 0, 0);
        exp_cyc("timeout_fail", 4'b0000, 3'd1, 0, 0, 1, 0);
        exp_cyc("timeout_fail", 4'b0000, 3'd1, 0, 0, 1, 0);
`else
        for (int i = 0; i < 1000; i++)
            exp_cyc("no_timeout", 4'b0000, 3'd1, 1, 0, 0, 0);
        press(2'b11, 1, 1);
        exp_cyc("append", 4'b0000, 3'd1, 0, 0, 0, 0);
`endif

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
